// File: rtl/oscillator_mixer.sv
// Sums the samples of all enabled oscillators into one wide unsigned value.
// One oscillator is added per cycle, so a single saturating adder serves
// any number of voices. The result, its enable mask and a one-cycle update
// strobe feed the output divider, which normalises by active-oscillator count.
module oscillator_mixer #(
    parameter int NUM_OSCILLATORS         = 8,
    parameter int SAMPLE_WIDTH            = 8,
    parameter int PRE_DIVISION_AUDIO_SIZE = 16
) (
    input  logic                                    clk_in,
    input  logic                                    rst_in,
    input  logic                                    sample_tick_in,
    input  logic [NUM_OSCILLATORS*SAMPLE_WIDTH-1:0] osc_samples_in,
    input  logic [NUM_OSCILLATORS-1:0]              osc_on_in,
    output logic [PRE_DIVISION_AUDIO_SIZE-1:0]      stream_out,
    output logic [NUM_OSCILLATORS-1:0]              is_on_out,
    output logic                                    has_updated,
    output logic                                    busy_out,
    output logic                                    overrun_out
);

    localparam int IDX_W = (NUM_OSCILLATORS > 1) ? $clog2(NUM_OSCILLATORS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OSCILLATORS - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    state_t                                  state;
    state_t                                  state_next;
    logic [IDX_W-1:0]                        index;
    logic [NUM_OSCILLATORS*SAMPLE_WIDTH-1:0] shadow_samples;
    logic [NUM_OSCILLATORS-1:0]              shadow_on;
    logic [PRE_DIVISION_AUDIO_SIZE-1:0]      accumulator;
    logic [SAMPLE_WIDTH-1:0]                 current_sample;
    logic [PRE_DIVISION_AUDIO_SIZE:0]        sum_wide;
    logic                                    tick_accept;

    // Select the voice being added this cycle and form the widened sum; the
    // extra carry bit tells us when to clamp instead of wrapping.
    always_comb begin
        current_sample = shadow_samples[index*SAMPLE_WIDTH +: SAMPLE_WIDTH];
        sum_wide       = {1'b0, accumulator} + (PRE_DIVISION_AUDIO_SIZE+1)'(current_sample);
        tick_accept    = (state == IDLE) && sample_tick_in;
    end

    // State register; reset wins over everything else.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: a tick is only honoured in IDLE, accumulation runs
    // once per voice, then a single DONE cycle publishes the result.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (sample_tick_in) state_next = ACCUM;
            ACCUM:   if (index == LAST_IDX) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: capture inputs at tick acceptance, accumulate with
    // saturation, publish in DONE, and flag ticks that arrive while busy.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            index          <= '0;
            accumulator    <= '0;
            shadow_samples <= '0;
            shadow_on      <= '0;
            stream_out     <= '0;
            is_on_out      <= '0;
            has_updated    <= 1'b0;
            busy_out       <= 1'b0;
            overrun_out    <= 1'b0;
        end else begin
            has_updated <= 1'b0;
            if (sample_tick_in && (state != IDLE)) begin
                overrun_out <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (tick_accept) begin
                        shadow_samples <= osc_samples_in;
                        shadow_on      <= osc_on_in;
                        accumulator    <= '0;
                        index          <= '0;
                        busy_out       <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (shadow_on[index]) begin
                        if (sum_wide[PRE_DIVISION_AUDIO_SIZE]) begin
                            accumulator <= '1;
                        end else begin
                            accumulator <= sum_wide[PRE_DIVISION_AUDIO_SIZE-1:0];
                        end
                    end
                    if (index != LAST_IDX) begin
                        index <= index + 1'b1;
                    end
                end
                DONE: begin
                    stream_out  <= accumulator;
                    is_on_out   <= shadow_on;
                    has_updated <= 1'b1;
                    busy_out    <= 1'b0;
                    index       <= '0;
                end
                default: begin
                    index <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_oscillator_mixer.sv
// Directed bench for oscillator_mixer: a default-sized instance plus a
// narrow (9-bit output) instance used for saturation and mid-mix reset.
module tb_oscillator_mixer;

    localparam int N  = 8;
    localparam int SW = 8;

    logic          clk_in;
    logic          rst0, rst1;
    logic          tick0, tick1;
    logic [N*SW-1:0] samples;
    logic [N-1:0]  osc_on;

    logic [15:0]   stream0;
    logic [N-1:0]  is_on0;
    logic          upd0, busy0, ovr0;
    logic [8:0]    stream1;
    logic [N-1:0]  is_on1;
    logic          upd1, busy1, ovr1;

    int checks;
    int errors;

    // Results gathered by runMix
    int            pulses;
    int            pulse_cycle;
    logic [31:0]   pulse_stream;
    logic [31:0]   pulse_is_on;
    logic          pulse_busy;
    logic          busy_first;

    oscillator_mixer #(
        .NUM_OSCILLATORS(N), .SAMPLE_WIDTH(SW), .PRE_DIVISION_AUDIO_SIZE(16)
    ) dut0 (
        .clk_in(clk_in), .rst_in(rst0), .sample_tick_in(tick0),
        .osc_samples_in(samples), .osc_on_in(osc_on),
        .stream_out(stream0), .is_on_out(is_on0), .has_updated(upd0),
        .busy_out(busy0), .overrun_out(ovr0)
    );

    oscillator_mixer #(
        .NUM_OSCILLATORS(N), .SAMPLE_WIDTH(SW), .PRE_DIVISION_AUDIO_SIZE(9)
    ) dut1 (
        .clk_in(clk_in), .rst_in(rst1), .sample_tick_in(tick1),
        .osc_samples_in(samples), .osc_on_in(osc_on),
        .stream_out(stream1), .is_on_out(is_on1), .has_updated(upd1),
        .busy_out(busy1), .overrun_out(ovr1)
    );

    // Free-running clock
    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic setRamp();
        for (int j = 0; j < N; j++) samples[j*SW +: SW] = 8'(8'h10 + j);
    endtask

    // Issue one tick to the selected instance, then run 25 cycles while
    // optionally clearing inputs, firing a second tick or asserting reset.
    // Cycle k means "just after edge T+k", where T samples the tick.
    task automatic applyStimulus(input int sel, input int clear_at,
                                 input int second_tick_at, input int reset_at);
        pulses = 0; pulse_cycle = -1;
        pulse_stream = '0; pulse_is_on = '0; pulse_busy = 1'b0; busy_first = 1'b0;
        @(posedge clk_in); #1;
        if (sel == 0) tick0 = 1'b1; else tick1 = 1'b1;
        @(posedge clk_in); #1;
        for (int k = 1; k <= 25; k++) begin
            if (sel == 0) tick0 = (k == second_tick_at);
            else          tick1 = (k == second_tick_at);
            if (k == clear_at) begin
                samples = '0;
                osc_on  = '0;
            end
            if (sel == 1) rst1 = (k == reset_at);
            @(posedge clk_in); #1;
            if (k == 1) busy_first = (sel == 0) ? busy0 : busy1;
            if (((sel == 0) ? upd0 : upd1) === 1'b1) begin
                pulses++;
                if (pulse_cycle < 0) begin
                    pulse_cycle  = k;
                    pulse_stream = (sel == 0) ? 32'(stream0) : 32'(stream1);
                    pulse_is_on  = (sel == 0) ? 32'(is_on0) : 32'(is_on1);
                    pulse_busy   = (sel == 0) ? busy0 : busy1;
                end
            end
        end
        tick0 = 1'b0;
        tick1 = 1'b0;
        rst1  = 1'b0;
    endtask

    // Directed sequence
    initial begin
        int upd_seen;
        checks = 0;
        errors = 0;
        tick0 = 1'b0; tick1 = 1'b0;
        rst0 = 1'b1;  rst1 = 1'b1;

        // Reset with random inputs
        for (int c = 0; c < 2; c++) begin
            samples = {$urandom, $urandom};
            osc_on  = 8'($urandom);
            tick0   = 1'($urandom);
            tick1   = 1'($urandom);
            @(posedge clk_in); #1;
        end
        rst0 = 1'b0; rst1 = 1'b0; tick0 = 1'b0; tick1 = 1'b0;
        checkOutput("rst_stream", 32'(stream0), 32'h0);
        checkOutput("rst_is_on", 32'(is_on0), 32'h0);
        checkOutput("rst_updated", 32'(upd0), 32'h0);
        checkOutput("rst_busy", 32'(busy0), 32'h0);
        checkOutput("rst_overrun", 32'(ovr0), 32'h0);
        checkOutput("rst_stream_narrow", 32'(stream1), 32'h0);
        upd_seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk_in); #1;
            if (upd0 || upd1 || busy0 || busy1) upd_seen++;
        end
        checkOutput("idle_quiet", 32'(upd_seen), 32'h0);

        // Ramp samples, all voices on: 8*0x10 + (0+..+7) = 0x9C
        setRamp(); osc_on = 8'hFF;
        applyStimulus(0, -1, -1, -1);
        checkOutput("ramp_busy_t1", 32'(busy_first), 32'h1);
        checkOutput("ramp_pulses", 32'(pulses), 32'h1);
        checkOutput("ramp_latency", 32'(pulse_cycle), 32'(N + 1));
        checkOutput("ramp_stream", pulse_stream, 32'h009C);
        checkOutput("ramp_is_on", pulse_is_on, 32'hFF);
        checkOutput("ramp_busy_done", 32'(pulse_busy), 32'h0);
        checkOutput("ramp_overrun", 32'(ovr0), 32'h0);

        // Two voices at 0xFF; inputs cleared mid-mix must not matter
        samples = '1; osc_on = 8'b0000_0101;
        applyStimulus(0, 2, -1, -1);
        checkOutput("capture_stream", pulse_stream, 32'h01FE);
        checkOutput("capture_is_on", pulse_is_on, 32'h05);
        checkOutput("held_stream", 32'(stream0), 32'h01FE);

        // All voices off still strobes with a zero sum
        samples = '1; osc_on = 8'h00;
        applyStimulus(0, -1, -1, -1);
        checkOutput("off_pulses", 32'(pulses), 32'h1);
        checkOutput("off_stream", pulse_stream, 32'h0);
        checkOutput("off_is_on", pulse_is_on, 32'h0);

        // Tick during ACCUM is dropped and flagged; overrun is sticky
        setRamp(); osc_on = 8'hFF;
        applyStimulus(0, -1, 3, -1);
        checkOutput("ovr_pulses", 32'(pulses), 32'h1);
        checkOutput("ovr_stream", pulse_stream, 32'h009C);
        checkOutput("ovr_flag", 32'(ovr0), 32'h1);
        samples = '1; osc_on = 8'hF0;
        applyStimulus(0, -1, -1, -1);
        checkOutput("after_ovr_stream", pulse_stream, 32'h03FC);
        checkOutput("after_ovr_is_on", pulse_is_on, 32'hF0);
        checkOutput("ovr_sticky", 32'(ovr0), 32'h1);

        // Narrow instance: saturation, and a tick landing in DONE is dropped
        samples = '1; osc_on = 8'hFF;
        applyStimulus(1, -1, N + 1, -1);
        checkOutput("sat_pulses", 32'(pulses), 32'h1);
        checkOutput("sat_stream", pulse_stream, 32'h1FF);
        checkOutput("sat_is_on", pulse_is_on, 32'hFF);
        checkOutput("done_tick_ovr", 32'(ovr1), 32'h1);

        // Reset mid-mix: no strobe, everything back to zero
        samples = '1; osc_on = 8'h0F;
        applyStimulus(1, -1, -1, 4);
        checkOutput("midrst_pulses", 32'(pulses), 32'h0);
        checkOutput("midrst_stream", 32'(stream1), 32'h0);
        checkOutput("midrst_is_on", 32'(is_on1), 32'h0);
        checkOutput("midrst_busy", 32'(busy1), 32'h0);
        checkOutput("midrst_overrun", 32'(ovr1), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
